// File: rtl/cv32e40p_ecc_pkg.sv
// Shared constants and FSM state type for the Hamming(38,32) background scrubber.
package cv32e40p_ecc_pkg;

    localparam int unsigned CW_W   = 38;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SYN_W  = 6;

    // Codeword bit indices holding parity (positions 1,2,4,8,16,32).
    localparam int unsigned PAR_POS [SYN_W] = '{0, 1, 3, 7, 15, 31};

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRdReq,
        StRdWait,
        StCheck,
        StWrReq,
        StNext
    } scrub_state_e;

endpackage

// File: rtl/cv32e40p_hamming_syndrome.sv
// Combinational SEC syndrome and single-bit correction for a 38-bit Hamming codeword.
module cv32e40p_hamming_syndrome
    import cv32e40p_ecc_pkg::*;
(
    input  logic [CW_W-1:0]  codeword,
    output logic [SYN_W-1:0] syndrome,
    output logic [CW_W-1:0]  corrected
);

    always_comb begin
        syndrome = '0;
        for (int k = 0; k < SYN_W; k++) begin
            for (int i = 0; i < CW_W; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syndrome[k] = syndrome[k] ^ codeword[i];
                end
            end
        end
    end

    always_comb begin
        corrected = codeword;
        if (syndrome != '0 && syndrome <= SYN_W'(CW_W)) begin
            corrected[syndrome - SYN_W'(1)] = ~codeword[syndrome - SYN_W'(1)];
        end
    end

endmodule

// File: rtl/cv32e40p_ecc_scrubber.sv
// Background ECC scrubber: walks the memory, corrects single-bit errors, flags the rest.
// Optional saturating error counters are built when CV32E40P_ECC_SCRUB_CNT_EN is defined.
module cv32e40p_ecc_scrubber
    import cv32e40p_ecc_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scrub_en_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [CW_W-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [CW_W-1:0]   mem_rdata_i,
    output logic              corr_o,
    output logic              uncorr_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic              pass_done_o
`ifdef CV32E40P_ECC_SCRUB_CNT_EN
    ,
    output logic [15:0]       corr_cnt_o,
    output logic [15:0]       uncorr_cnt_o
`endif
);

    localparam int unsigned       CNT_W    = $clog2(INTERVAL + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d, race_q, race_d;
    logic              corr_q, corr_d, uncorr_q, uncorr_d, pass_done_q, pass_done_d;
    logic [CW_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SYN_W-1:0]  syndrome;
    logic [CW_W-1:0]   corrected;
    logic              core_wr_hit;

    cv32e40p_hamming_syndrome u_syndrome (
        .codeword  (rdata_q),
        .syndrome  (syndrome),
        .corrected (corrected)
    );

    assign core_wr_hit = core_req_i & core_we_i & (core_addr_i == addr_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        race_d      = race_q;
        err_addr_d  = err_addr_q;
        corr_d      = 1'b0;
        uncorr_d    = 1'b0;
        pass_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = CNT_INIT;
                if (scrub_en_i) state_d = StWait;
            end
            StWait: begin
                if (!scrub_en_i) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StRdReq;
                    race_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRdReq: begin
                // A raised request is never withdrawn before its grant.
                if (req_q) begin
                    if (mem_gnt_i) begin
                        req_d   = 1'b0;
                        state_d = StRdWait;
                    end
                end else if (!scrub_en_i) begin
                    state_d = StIdle;
                end else if (!core_req_i) begin
                    req_d = 1'b1;
                    we_d  = 1'b0;
                end
            end
            StRdWait: begin
                if (core_wr_hit) race_d = 1'b1;
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (syndrome == '0) begin
                    state_d = StNext;
                end else if (syndrome <= SYN_W'(CW_W)) begin
                    corr_d     = 1'b1;
                    err_addr_d = addr_q;
                    wdata_d    = corrected;
                    state_d    = (race_q || core_wr_hit) ? StNext : StWrReq;
                end else begin
                    uncorr_d   = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = StNext;
                end
            end
            StWrReq: begin
                if (req_q) begin
                    if (mem_gnt_i) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = StNext;
                    end
                end else if (race_q || core_wr_hit) begin
                    // Core overwrote the word since our read; our correction is stale.
                    state_d = StNext;
                end else if (!core_req_i) begin
                    req_d = 1'b1;
                    we_d  = 1'b1;
                end
            end
            StNext: begin
                pass_done_d = (addr_q == LAST);
                addr_d      = (addr_q == LAST) ? '0 : addr_q + ADDR_W'(1);
                cnt_d       = CNT_INIT;
                state_d     = scrub_en_i ? StWait : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= CNT_INIT;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            race_q      <= 1'b0;
            err_addr_q  <= '0;
            corr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            race_q      <= race_d;
            err_addr_q  <= err_addr_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign corr_o      = corr_q;
    assign uncorr_o    = uncorr_q;
    assign err_addr_o  = err_addr_q;
    assign pass_done_o = pass_done_q;

`ifdef CV32E40P_ECC_SCRUB_CNT_EN
    logic [15:0] corr_cnt_q, uncorr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (corr_q && corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 16'd1;
            if (uncorr_q && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
        end
    end

    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40p_ecc_scrubber.sv
// Self-checking bench for cv32e40p_ecc_scrubber with a small OBI memory model.
module tb_cv32e40p_ecc_scrubber;
    import cv32e40p_ecc_pkg::*;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;
    localparam int INTERVAL = 2;

    logic              clk = 1'b0;
    logic              rst_n, scrub_en, core_req, core_we;
    logic [ADDR_W-1:0] core_addr, mem_addr, err_addr;
    logic              mem_req, mem_gnt, mem_we, mem_rvalid, corr, uncorr, pass_done;
    logic [37:0]       mem_wdata, mem_rdata;
`ifdef CV32E40P_ECC_SCRUB_CNT_EN
    logic [15:0]       corr_cnt, uncorr_cnt;
`endif

    cv32e40p_ecc_scrubber #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL(INTERVAL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scrub_en_i   (scrub_en),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .corr_o       (corr),
        .uncorr_o     (uncorr),
        .err_addr_o   (err_addr),
        .pass_done_o  (pass_done)
`ifdef CV32E40P_ECC_SCRUB_CNT_EN
        ,
        .corr_cnt_o   (corr_cnt),
        .uncorr_cnt_o (uncorr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: contents owned by the test process, responder only reads them.
    logic [37:0] mem [DEPTH];
    logic        gnt_rand, gnt_hold, rd_pend;
    logic [37:0] rd_data;
    int          rd_wait, rv_min, rv_max;

    assign mem_gnt = mem_req & gnt_rand & ~gnt_hold;

    always @(posedge clk) gnt_rand <= ($urandom_range(0, 3) != 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
            rd_pend    <= 1'b0;
        end else begin
            mem_rvalid <= 1'b0;
            if (rd_pend) begin
                if (rd_wait == 0) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= rd_data;
                    rd_pend    <= 1'b0;
                end else begin
                    rd_wait <= rd_wait - 1;
                end
            end
            if (mem_req && mem_gnt && !mem_we) begin
                rd_pend <= 1'b1;
                rd_data <= mem[mem_addr];
                rd_wait <= $urandom_range(rv_max, rv_min);
            end
        end
    end

    // Transaction / pulse log, sampled mid-cycle.
    int          rd_q[$];
    int          wr_a[$];
    logic [37:0] wr_d[$];
    int          corr_n, unc_n, pd_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            corr_n <= 0;
            unc_n  <= 0;
            pd_n   <= 0;
        end else begin
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    wr_a.push_back(int'(mem_addr));
                    wr_d.push_back(mem_wdata);
                end else begin
                    rd_q.push_back(int'(mem_addr));
                end
            end
            if (corr) corr_n <= corr_n + 1;
            if (uncorr) unc_n <= unc_n + 1;
            if (pass_done) pd_n <= pd_n + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int rd0, wr0, corr0, unc0, pd0, exp_err;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Syndrome as the XOR of the 1-based positions of all set bits.
    function automatic int syn_of(input logic [37:0] cw);
        int s = 0;
        for (int i = 0; i < 38; i++) if (cw[i]) s = s ^ (i + 1);
        return s;
    endfunction

    function automatic logic [37:0] encode(input logic [31:0] d);
        logic [37:0] cw = '0;
        int j = 0;
        int x = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                if (d[j]) x = x ^ p;
                j++;
            end
        end
        for (int k = 0; k < 6; k++) cw[PAR_POS[k]] = x[k];
        return cw;
    endfunction

    task automatic load_clean();
        for (int a = 0; a < DEPTH; a++) mem[a] = encode($urandom());
    endtask

    task automatic snap();
        rd0 = rd_q.size(); wr0 = wr_a.size();
        corr0 = corr_n; unc0 = unc_n; pd0 = pd_n;
    endtask

    task automatic wait_pass();
        int n = 0;
        scrub_en = 1'b1;
        @(negedge clk);
        while (!pass_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pass_done_seen", pass_done, 1);
        scrub_en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Expected pass outcome derived from memory contents; skip = address whose write-back is raced.
    task automatic check_model(input string name, input int skip);
        int          ec = 0;
        int          eu = 0;
        int          wa[$];
        logic [37:0] wd[$];
        for (int a = 0; a < DEPTH; a++) begin
            logic [37:0] cw = mem[a];
            int s = syn_of(cw);
            if (s >= 1 && s <= 38) begin
                ec++;
                exp_err = a;
                cw[s-1] = ~cw[s-1];
                if (a != skip) begin
                    wa.push_back(a);
                    wd.push_back(cw);
                end
            end else if (s > 38) begin
                eu++;
                exp_err = a;
            end
        end
        check({name, " reads"}, rd_q.size() - rd0, DEPTH);
        for (int i = 0; i < DEPTH && rd0 + i < rd_q.size(); i++)
            check({name, " rd_addr"}, rd_q[rd0+i], i);
        check({name, " writes"}, wr_a.size() - wr0, wa.size());
        for (int i = 0; i < wa.size() && wr0 + i < wr_a.size(); i++) begin
            check({name, " wr_addr"}, wr_a[wr0+i], wa[i]);
            check({name, " wr_data"}, wr_d[wr0+i], wd[i]);
        end
        check({name, " corr_pulses"}, corr_n - corr0, ec);
        check({name, " uncorr_pulses"}, unc_n - unc0, eu);
        check({name, " pass_done_pulses"}, pd_n - pd0, 1);
        check({name, " err_addr"}, err_addr, exp_err);
        check({name, " addr_wrapped"}, mem_addr, 0);
    endtask

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [37:0] flip;
        bit          exp_corr;
        bit          exp_unc;
        logic [37:0] exp_wdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          viol;
        logic [1:0]  a0;
        logic [37:0] one = 38'd1;

        vecs[0] = '{2, 32'hDEADBEEF, one << 9, 1'b1, 1'b0, encode(32'hDEADBEEF)};
        vecs[1] = '{1, 32'h0BAD_F00D, (one << 0) | (one << 37), 1'b0, 1'b1, '0};
        vecs[2] = '{1, 32'h1234_5678, (one << 36) | (one << 37), 1'b1, 1'b0,
                    encode(32'h1234_5678) ^ (one << 36) ^ (one << 37) ^ (one << 2)};
        vecs[3] = '{0, 32'hCAFE_0001, one << 37, 1'b1, 1'b0, encode(32'hCAFE_0001)};
        vecs[4] = '{3, 32'hFFFF_FFFF, one << 0, 1'b1, 1'b0, encode(32'hFFFF_FFFF)};
        vecs[5] = '{0, 32'h8000_0000, one << 31, 1'b1, 1'b0, encode(32'h8000_0000)};
        vecs[6] = '{1, 32'h5555_AAAA, '0, 1'b0, 1'b0, '0};

        rst_n = 1'b0; scrub_en = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0;
        gnt_hold = 1'b0; rv_min = 0; rv_max = 2; exp_err = 0;
        load_clean();
        repeat (3) @(negedge clk);
        check("reset mem_req", mem_req, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset pulses", {corr, uncorr, pass_done}, 0);
        check("reset err_addr", err_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        snap();
        wait_pass();
        check_model("clean", -1);

        foreach (vecs[r]) begin
            load_clean();
            mem[vecs[r].addr] = encode(vecs[r].data) ^ vecs[r].flip;
            snap();
            wait_pass();
            check_model($sformatf("vec%0d", r), -1);
            check($sformatf("vec%0d corr", r), corr_n - corr0, vecs[r].exp_corr);
            check($sformatf("vec%0d uncorr", r), unc_n - unc0, vecs[r].exp_unc);
            if (vecs[r].exp_corr && wr_a.size() > wr0)
                check($sformatf("vec%0d wdata", r), wr_d[wr0], vecs[r].exp_wdata);
        end

        // Core write to the word being scrubbed between read grant and write-back.
        load_clean();
        mem[2] = encode(32'h0F0F_1234) ^ (one << 20);
        snap();
        scrub_en = 1'b1;
        viol = 0;
        while (!(mem_req && mem_gnt && !mem_we && mem_addr == 2'd2) && viol < 500) begin
            @(negedge clk);
            viol++;
        end
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 2'd2;
        @(posedge clk); #1;
        core_req = 1'b0; core_we = 1'b0;
        wait_pass();
        check_model("race", 2);

        // Core hogs the port, then grant stalls with the request raised.
        load_clean();
        snap();
        @(posedge clk); #1;
        core_req = 1'b1; core_addr = 2'd3; scrub_en = 1'b1;
        viol = 0;
        repeat (14) begin
            @(negedge clk);
            if (mem_req) viol++;
        end
        check("stall req_while_core", viol, 0);
        @(posedge clk); #1;
        core_req = 1'b0; gnt_hold = 1'b1;
        @(negedge clk);
        check("stall req_in_fall_cycle", mem_req, 0);
        @(negedge clk);
        check("stall req_after_fall", mem_req, 1);
        a0 = mem_addr;
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (!mem_req || mem_addr != a0 || mem_we) viol++;
        end
        check("stall stable", viol, 0);
        check("stall addr", a0, 0);
        @(posedge clk); #1;
        gnt_hold = 1'b0;
        wait_pass();
        check_model("stall", -1);

        // Random contents with 0, 1 or 2 flipped bits per word.
        rv_max = 3;
        for (int p = 0; p < 8; p++) begin
            load_clean();
            for (int a = 0; a < DEPTH; a++) begin
                int b1 = $urandom_range(0, 37);
                int b2 = (b1 + 1 + $urandom_range(0, 36)) % 38;
                case ($urandom_range(0, 2))
                    1: mem[a] = mem[a] ^ (one << b1);
                    2: mem[a] = mem[a] ^ (one << b1) ^ (one << b2);
                    default: ;
                endcase
            end
            snap();
            wait_pass();
            check_model($sformatf("rand%0d", p), -1);
        end

`ifdef CV32E40P_ECC_SCRUB_CNT_EN
        check("corr_cnt", corr_cnt, corr_n);
        check("uncorr_cnt", uncorr_cnt, unc_n);
`endif

        // Reset while a read is outstanding.
        load_clean();
        mem[0] = mem[0] ^ (one << 5);
        rv_min = 4; rv_max = 4;
        scrub_en = 1'b1;
        viol = 0;
        while (!(mem_req && mem_gnt && !mem_we && mem_addr == 2'd1) && viol < 500) begin
            @(negedge clk);
            viol++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst req", mem_req, 0);
        check("async_rst addr", mem_addr, 0);
        check("async_rst we", mem_we, 0);
        check("async_rst wdata", mem_wdata, 0);
        check("async_rst err_addr", err_addr, 0);
        check("async_rst pulses", {corr, uncorr, pass_done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd0 = rd_q.size();
        viol = 0;
        while (rd_q.size() == rd0 && viol < 500) begin
            @(negedge clk);
            viol++;
        end
        check("post_rst read_seen", rd_q.size() > rd0, 1);
        if (rd_q.size() > rd0) check("post_rst first_addr", rd_q[rd0], 0);
        scrub_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
